// File: rtl/data_merge_arbiter_pkg.sv
// Shared types and helpers for the data merge arbiter.
// Holds the FSM state encoding, the default word width and the
// round-robin search function used by the top level.
package data_arb_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int MAX_SRC    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set request bit at or after ptr, scanning cyclically. Unused
  // positions above WIDTH are always zero, so wrapping over all 8 slots
  // gives the same order as wrapping at WIDTH.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                       input logic [2:0]         ptr);
    rr_pick_t   r;
    logic [2:0] i;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int k = 0; k < MAX_SRC; k++) begin
      i = ptr + 3'(k);
      if (!r.found && req[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_skid_buf.sv
// Two-entry register FIFO between the arbiter and the sink.
// in_space already counts the entry leaving on this cycle's out_ready, so a
// full buffer with a ready sink still takes one word per clock.
module arb_skid_buf
  import data_arb_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_space,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic [1:0]    count_q;
  logic          push;
  logic          pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign in_space  = (count_q != 2'd2) || out_ready;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && in_space;

  // Head always holds the oldest word; tail is used only when two are stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 tail_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= in_data;
          end else begin
            head_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_merge_arbiter.sv
// Round-robin merge of WIDTH FWFT readout FIFOs into one word stream.
// A source holding HOLD_REQ keeps the grant so multi-word records stay
// contiguous. Optional per-source pop counters: define ARB_STATS_EN.
//
// Handshake: a word moves to the sink on every clock where WRITE_OUT and
// READY_IN are both high; DATA_OUT is held while WRITE_OUT=1 and READY_IN=0.
// A source is popped on every clock its READ_GRANT bit is high.
module data_merge_arbiter
  import data_arb_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST_N,
  input  logic [WIDTH-1:0]    WRITE_REQ,
  input  logic [WIDTH-1:0]    HOLD_REQ,
  input  logic [WIDTH*DW-1:0] DATA_IN,
  output logic [WIDTH-1:0]    READ_GRANT,
  input  logic                READY_IN,
  output logic                WRITE_OUT,
  output logic [DW-1:0]       DATA_OUT,
  output logic [2:0]          GRANT_IDX,
`ifdef ARB_STATS_EN
  output logic [WIDTH*16-1:0] ARB_WORD_CNT,
`endif
  output logic [1:0]          FSM_STATE
);

  if (WIDTH < 1 || WIDTH > MAX_SRC) begin : g_width_check
    $error("data_merge_arbiter: WIDTH must be in 1..8");
  end

  arb_state_t         state_q, state_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         rr_q, rr_d;
  logic [2:0]         ptr_next;
  logic [MAX_SRC-1:0] req_ext;
  logic [MAX_SRC-1:0] hold_ext;
  rr_pick_t           pick_idle, pick_next;
  logic               buf_space;
  logic               pop;
  logic               release_now;
  logic [DW-1:0]      pop_data;

  assign req_ext   = MAX_SRC'(WRITE_REQ);
  assign hold_ext  = MAX_SRC'(HOLD_REQ);
  assign ptr_next  = (owner_q == 3'(WIDTH-1)) ? 3'd0 : owner_q + 3'd1;
  assign pick_idle = rr_pick(req_ext, rr_q);
  assign pick_next = rr_pick(req_ext, ptr_next);
  assign GRANT_IDX = owner_q;
  assign FSM_STATE = state_q;

  // State, owner and round-robin pointer registers.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= IDLE;
      owner_q <= 3'd0;
      rr_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Next state, pop strobe and same-cycle re-arbitration on release.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    pop         = 1'b0;
    release_now = 1'b0;
    READ_GRANT  = '0;
    case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d = GRANT;
          owner_d = pick_idle.idx;
        end
      end
      GRANT, HOLD: begin
        pop = req_ext[owner_q] && buf_space;
        if (state_q == GRANT) begin
          if (!req_ext[owner_q] || pop) begin
            if (hold_ext[owner_q]) state_d = HOLD;
            else                   release_now = 1'b1;
          end
        end else if (!hold_ext[owner_q]) begin
          release_now = 1'b1;
        end
        if (release_now) begin
          rr_d = ptr_next;
          if (pick_next.found) begin
            state_d = GRANT;
            owner_d = pick_next.idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < WIDTH; i++) begin
      READ_GRANT[i] = pop && (owner_q == 3'(i));
    end
  end

  // Select the owner's FWFT head word for the skid buffer.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (owner_q == 3'(i)) pop_data = DATA_IN[i*DW +: DW];
    end
  end

  arb_skid_buf #(.DW(DW)) u_skid (
    .clk      (BUS_CLK),
    .rst_n    (BUS_RST_N),
    .in_valid (pop),
    .in_data  (pop_data),
    .in_space (buf_space),
    .out_valid(WRITE_OUT),
    .out_ready(READY_IN),
    .out_data (DATA_OUT)
  );

`ifdef ARB_STATS_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_stat
    logic [15:0] cnt_q;
    // Saturating count of words popped from source i.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N)                             cnt_q <= 16'd0;
      else if (READ_GRANT[i] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign ARB_WORD_CNT[i*16 +: 16] = cnt_q;
  end
`endif

endmodule
